// File: rtl/dout_event_receiver.sv
// Deframes the SURF event readout byte stream into header fields and a
// 32-bit AXI4-Stream payload, flagging sequence, overflow and gap errors.
module dout_event_receiver #(
    parameter int PAYLOAD_BYTES = 12288,
    parameter int FIFO_DEPTH    = 16,
    parameter int GAP_TIMEOUT   = 255
) (
    input  logic        ifclk_i,
    input  logic        ifclk_rstb_i,
    input  logic [7:0]  dout_data_i,
    input  logic        dout_data_valid_i,
    output logic        dout_data_phase_o,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic [15:0] hdr_event_no_o,
    output logic [14:0] hdr_trig_time_o,
    output logic        hdr_valid_o,
    output logic        seq_err_o,
    output logic        ovf_err_o,
    output logic        gap_err_o,
    input  logic        err_clear_i,
    output logic [15:0] frame_count_o
);
    localparam int PW = (PAYLOAD_BYTES > 2) ? $clog2(PAYLOAD_BYTES) : 2;
    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;

    state_t         state;
    logic [1:0]     hcnt;
    logic [15:0]    ev_buf;
    logic [6:0]     trig_hi;
    logic [PW-1:0]  pay_cnt;
    logic [23:0]    sh;
    logic [15:0]    gap_cnt;
    logic [31:0]    word_data;
    logic           word_rdy;
    logic           word_last;
    logic           pending_last;
    logic           seq_valid;
    logic [15:0]    seq_prev;

    logic [33:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [CW-1:0]  count;
    logic [33:0]    rd;
    logic [33:0]    push_data;
    logic           pop;
    logic           full;
    logic           can_push;
    logic           pend_push;
    logic           word_push;
    logic           word_ovf;
    logic           push;

    logic           pay_last;
    logic           gap_hit;
    logic           word_end;

    assign pay_last = pay_cnt == PW'(PAYLOAD_BYTES - 1);
    assign gap_hit  = gap_cnt == 16'(GAP_TIMEOUT - 1);
    assign word_end = pay_cnt[1:0] == 2'd3;

    assign m_axis_tvalid = count != '0;
    assign rd            = mem[rptr];
    assign m_axis_tdata  = m_axis_tvalid ? rd[33:2] : '0;
    assign m_axis_tlast  = m_axis_tvalid & rd[1];
    assign m_axis_tuser  = m_axis_tvalid & rd[0];

    assign pop      = m_axis_tvalid & m_axis_tready;
    assign full     = count == CW'(FIFO_DEPTH);
    assign can_push = !full || pop;

    // The abort marker wins the write port; a word blocked only by the
    // marker waits one cycle, a word blocked by a full FIFO is lost.
    assign pend_push = pending_last & can_push;
    assign word_push = word_rdy & ~pending_last & can_push;
    assign word_ovf  = word_rdy & ~can_push;
    assign push      = pend_push | word_push;
    assign push_data = pend_push ? {32'hDEADDEAD, 1'b1, 1'b1}
                                 : {word_data, word_last, 1'b0};

    always_ff @(posedge ifclk_i) begin
        if (push) mem[wptr] <= push_data;
    end

    always_ff @(posedge ifclk_i or negedge ifclk_rstb_i) begin
        if (!ifclk_rstb_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge ifclk_i or negedge ifclk_rstb_i) begin
        if (!ifclk_rstb_i) begin
            state             <= IDLE;
            hcnt              <= '0;
            ev_buf            <= '0;
            trig_hi           <= '0;
            pay_cnt           <= '0;
            sh                <= '0;
            gap_cnt           <= '0;
            word_data         <= '0;
            word_rdy          <= 1'b0;
            word_last         <= 1'b0;
            pending_last      <= 1'b0;
            seq_valid         <= 1'b0;
            seq_prev          <= '0;
            dout_data_phase_o <= 1'b0;
            hdr_event_no_o    <= '0;
            hdr_trig_time_o   <= '0;
            hdr_valid_o       <= 1'b0;
            seq_err_o         <= 1'b0;
            ovf_err_o         <= 1'b0;
            gap_err_o         <= 1'b0;
            frame_count_o     <= '0;
        end else begin
            dout_data_phase_o <= ~dout_data_phase_o;
            hdr_valid_o       <= 1'b0;

            if (word_push || word_ovf) word_rdy <= 1'b0;
            if (pend_push) pending_last <= 1'b0;

            if (err_clear_i) begin
                seq_err_o <= 1'b0;
                ovf_err_o <= 1'b0;
                gap_err_o <= 1'b0;
                seq_valid <= 1'b0;
            end

            if (word_ovf) begin
                ovf_err_o <= 1'b1;
                if (word_last) pending_last <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    gap_cnt <= '0;
                    if (dout_data_valid_i) begin
                        ev_buf[15:8] <= dout_data_i;
                        hcnt         <= 2'd1;
                        state        <= HDR;
                    end
                end
                HDR: begin
                    if (dout_data_valid_i) begin
                        gap_cnt <= '0;
                        hcnt    <= hcnt + 2'd1;
                        if (hcnt == 2'd1) ev_buf[7:0] <= dout_data_i;
                        if (hcnt == 2'd2) trig_hi <= dout_data_i[6:0];
                        if (hcnt == 2'd3) begin
                            hdr_event_no_o  <= ev_buf;
                            hdr_trig_time_o <= {trig_hi, dout_data_i};
                            hdr_valid_o     <= 1'b1;
                            if (seq_valid && ev_buf != seq_prev + 16'd1)
                                seq_err_o <= 1'b1;
                            seq_prev  <= ev_buf;
                            seq_valid <= 1'b1;
                            pay_cnt   <= '0;
                            state     <= PAYLOAD;
                        end
                    end else if (gap_hit) begin
                        gap_err_o <= 1'b1;
                        gap_cnt   <= '0;
                        state     <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                PAYLOAD: begin
                    if (dout_data_valid_i) begin
                        gap_cnt <= '0;
                        sh      <= {sh[15:0], dout_data_i};
                        pay_cnt <= pay_cnt + PW'(1);
                        if (word_end) begin
                            word_data <= {sh, dout_data_i};
                            word_rdy  <= 1'b1;
                            word_last <= pay_last;
                        end
                        if (pay_last) begin
                            frame_count_o <= frame_count_o + 16'd1;
                            state         <= IDLE;
                        end else if (word_ovf) begin
                            state <= DROP;
                        end
                    end else if (gap_hit) begin
                        gap_err_o    <= 1'b1;
                        pending_last <= 1'b1;
                        gap_cnt      <= '0;
                        state        <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                        if (word_ovf) state <= DROP;
                    end
                end
                DROP: begin
                    if (dout_data_valid_i) begin
                        pay_cnt <= pay_cnt + PW'(1);
                        if (pay_last) begin
                            frame_count_o <= frame_count_o + 16'd1;
                            pending_last  <= 1'b1;
                            state         <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dout_event_receiver.md
Name: dout_event_receiver

Overview:
Receiving end of the SURF event readout byte stream driven by the URAM event buffer (dout_data_o / dout_data_valid_o / dout_data_phase_i).
- Generates the phase strobe the buffer consumes.
- Deframes each event into a 4-byte header plus fixed-length payload.
- Repacks the payload into a 32-bit AXI4-Stream with tlast and flags sequence, overflow and gap errors.
- Used as the TURFIO-side capture block and as an on-chip loopback checker for the readout path.

Parameters:
PAYLOAD_BYTES, 12288, payload bytes per event after header; must be a multiple of 4 and at least 4.
FIFO_DEPTH, 16, output word FIFO depth; must be a power of 2.
GAP_TIMEOUT, 255, consecutive idle cycles allowed mid-frame before abort; range 1..65535.

Ports:
ifclk_i  in  1  interface clock; sole clock.
ifclk_rstb_i  in  1  asynchronous active-low reset.
dout_data_i  in  8  event byte from the event buffer.
dout_data_valid_i  in  1  byte qualifier; no backpressure is available upstream.
dout_data_phase_o  out  1  phase strobe to the event buffer.
m_axis_tdata  out  32  packed payload word.
m_axis_tvalid  out  1  output valid.
m_axis_tready  in  1  output ready.
m_axis_tlast  out  1  last word of frame.
m_axis_tuser  out  1  1 = frame truncated or errored.
hdr_event_no_o  out  16  event number from the header.
hdr_trig_time_o  out  15  trigger time from the header.
hdr_valid_o  out  1  one-cycle header strobe.
seq_err_o  out  1  sticky: event number not equal to previous + 1.
ovf_err_o  out  1  sticky: FIFO overflow.
gap_err_o  out  1  sticky: mid-frame gap timeout.
err_clear_i  in  1  clears all sticky errors.
frame_count_o  out  16  completed frames, wraps modulo 2^16.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFO empty, state IDLE, pending_last 0, seq expectation invalid.
- dout_data_phase_o toggles every cycle out of reset.
- A byte is accepted on any cycle with dout_data_valid_i=1.
- States:
  - IDLE: first accepted byte becomes header byte 0; go to HDR.
  - HDR: header byte order is event_no[15:8], event_no[7:0], {x, trig_time[14:8]}, trig_time[7:0]. After the 4th byte: register hdr_event_no_o/hdr_trig_time_o; pulse hdr_valid_o the next cycle; go to PAYLOAD.
  - PAYLOAD: pack big-endian, first byte into tdata[31:24]. The completed word is pushed into the FIFO the cycle after its 4th byte. The word holding the final payload byte has tlast=1 and tuser=0. After the final byte, increment frame_count_o and go to IDLE.
  - DROP: entered when a push finds the FIFO full. The word is discarded, ovf_err_o is set, and remaining payload bytes are discarded. At the final byte, increment frame_count_o, set pending_last and go to IDLE.
- Sequence check:
  - The first header after reset or err_clear_i only loads the expectation.
  - After that, event_no != prev+1 (mod 2^16) sets seq_err_o.
  - The expectation always reloads with the received number.
- Gap handling:
  - In HDR or PAYLOAD, GAP_TIMEOUT consecutive cycles with valid=0 set gap_err_o and return to IDLE.
  - A partial word is discarded.
  - If aborted from PAYLOAD, set pending_last.
  - The idle counter resets on every accepted byte.
- pending_last:
  - Pushes word 32'hDEADDEAD with tlast=1, tuser=1 as soon as the FIFO is not full. It has priority over any payload push that cycle.
  - A payload push that collides while pending_last is still set and the FIFO is full sends that frame to DROP.
- FIFO: first-word-fall-through, so tdata/tlast/tuser are valid whenever tvalid=1. Standard AXI handshake; push and pop in the same cycle while full is allowed (not an overflow).
- Boundary behaviour:
  - FIFO-full detection is exact at FIFO_DEPTH entries.
  - frame_count_o and the sequence check wrap at 0xFFFF→0x0000; 0xFFFF→0x0000 is not a sequence error.
- Errors: sticky bits clear on err_clear_i. An error condition in the same cycle as err_clear_i leaves the bit set.
- Latency: last byte accepted → m_axis_tvalid in 2 cycles when the FIFO is empty.

Test Plan:
1. PAYLOAD_BYTES=8. Send 00 05 01 23 then 11 22 33 44 55 66 77 88, tready=1 → hdr_valid pulse with event_no=0x0005, trig_time=0x0123; words 0x11223344 (tlast 0), 0x55667788 (tlast 1, tuser 0); frame_count=1.
2. Two frames with event_no 0x0007 then 0x0009 → seq_err_o=1 after the second header. Frames 0xFFFF then 0x0000 → seq_err_o stays 0.
3. FIFO_DEPTH=4, PAYLOAD_BYTES=32, tready=0 → 4 words stored, ovf_err_o=1, remaining bytes dropped. Raise tready → 4 words, then 0xDEADDEAD with tlast=1, tuser=1.
4. GAP_TIMEOUT=10. Stall valid 10 cycles after payload byte 5 → gap_err_o=1, one good word then the DEADDEAD marker. The next frame deframes correctly.
5. Stall 9 cycles mid-payload → no error, frame intact.
6. Assert ifclk_rstb_i mid-payload with the FIFO holding 3 words → tvalid=0, counters and errors 0, phase 0. After release, a fresh frame is received correctly.
